regfile_wb_arbiter: RTL

Write-port arbiter for the 32x32 integer register file. Two writeback requesters share the single register-file write port: source 0 is the pipeline WB stage and source 1 is the multi-cycle load/return unit. The block grants one write per cycle through a registered output stage. It exposes forwarding for the write currently held in that stage and counts contention stalls. It sits between the writeback sources and the register file's `i_rd_wren`/`i_rd_addr`/`i_rd_data` inputs.

---
 rtl/regfile_wb_arbiter_if.sv | 53 +++++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback, register-file write, forwarding and counter signals.
// The arbiter connects through the slave modport; the sources and the
// register file connect through the master modport.
interface regfile_wb_arbiter_if #(
   parameter int CNT_W = 16
);
   // writeback source 0 (pipeline WB stage)
   logic             i_wb0_valid;
   logic [4:0]       i_wb0_addr;
   logic [31:0]      i_wb0_data;
   logic             o_wb0_ready;
   // writeback source 1 (load/return unit)
   logic             i_wb1_valid;
   logic [4:0]       i_wb1_addr;
   logic [31:0]      i_wb1_data;
   logic             o_wb1_ready;
   // register-file write port
   logic             o_rd_wren;
   logic [4:0]       o_rd_addr;
   logic [31:0]      o_rd_data;
   // decode-stage forwarding
   logic [4:0]       i_rs1_addr;
   logic [4:0]       i_rs2_addr;
   logic             o_rs1_fwd_valid;
   logic             o_rs2_fwd_valid;
   logic [31:0]      o_rs1_fwd_data;
   logic [31:0]      o_rs2_fwd_data;
   // contention statistics
   logic             i_cnt_clr;
   logic [CNT_W-1:0] o_conflict_cnt;

   modport slave (
      input  i_wb0_valid, i_wb0_addr, i_wb0_data,
      input  i_wb1_valid, i_wb1_addr, i_wb1_data,
      input  i_rs1_addr, i_rs2_addr, i_cnt_clr,
      output o_wb0_ready, o_wb1_ready,
      output o_rd_wren, o_rd_addr, o_rd_data,
      output o_rs1_fwd_valid, o_rs2_fwd_valid,
      output o_rs1_fwd_data, o_rs2_fwd_data,
      output o_conflict_cnt
   );

   modport master (
      output i_wb0_valid, i_wb0_addr, i_wb0_data,
      output i_wb1_valid, i_wb1_addr, i_wb1_data,
      output i_rs1_addr, i_rs2_addr, i_cnt_clr,
      input  o_wb0_ready, o_wb1_ready,
      input  o_rd_wren, o_rd_addr, o_rd_data,
      input  o_rs1_fwd_valid, o_rs2_fwd_valid,
      input  o_rs1_fwd_data, o_rs2_fwd_data,
      input  o_conflict_cnt
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 integer register file.
// Two writeback sources share one write port. One non-x0 write is granted
// per cycle into a registered output stage; x0 writes are acknowledged
// immediately and dropped. The staged write is forwarded to the decode
// read ports, and refused cycles are counted in a saturating counter.
module regfile_wb_arbiter #(
   parameter bit RR_EN = 1'b1,
   parameter int CNT_W = 16
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   regfile_wb_arbiter_if.slave  bus
);

   // Which source wins the next contended cycle.
   typedef enum logic {
      PTR_WB0 = 1'b0,
      PTR_WB1 = 1'b1
   } rr_ptr_t;

   rr_ptr_t          rr_ptr_q, rr_ptr_d;
   logic             wren_q, wren_d;
   logic [4:0]       addr_q, addr_d;
   logic [31:0]      data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic wb0_x0, wb1_x0;
   logic wb0_req, wb1_req;
   logic prefer0;
   logic win0, win1;
   logic stall;

   // Grant decision: depends only on valid/addr and the pointer, never on data.
   always_comb begin
      wb0_x0  = bus.i_wb0_valid & (bus.i_wb0_addr == 5'd0);
      wb1_x0  = bus.i_wb1_valid & (bus.i_wb1_addr == 5'd0);
      wb0_req = bus.i_wb0_valid & (bus.i_wb0_addr != 5'd0);
      wb1_req = bus.i_wb1_valid & (bus.i_wb1_addr != 5'd0);
      // Without round-robin source 0 always has priority.
      prefer0 = (RR_EN == 1'b0) || (rr_ptr_q == PTR_WB0);
      win0    = wb0_req & (~wb1_req | prefer0);
      win1    = wb1_req & ~win0;
      // At most one source can be refused in a cycle.
      stall   = (wb0_req & ~win0) | (wb1_req & ~win1);
   end

   // Ready is forced low while reset is held so no source believes it transferred.
   assign bus.o_wb0_ready = i_rst_n & (wb0_x0 | win0);
   assign bus.o_wb1_ready = i_rst_n & (wb1_x0 | win1);

   // Next-state for pointer, output stage and contention counter.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      wren_d   = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      cnt_d    = cnt_q;

      if (win0) begin
         rr_ptr_d = PTR_WB1;
         wren_d   = 1'b1;
         addr_d   = bus.i_wb0_addr;
         data_d   = bus.i_wb0_data;
      end else if (win1) begin
         rr_ptr_d = PTR_WB0;
         wren_d   = 1'b1;
         addr_d   = bus.i_wb1_addr;
         data_d   = bus.i_wb1_data;
      end

      // Clear beats increment; increment stops at all ones.
      if (bus.i_cnt_clr) begin
         cnt_d = '0;
      end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers; reset discards any staged write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr_q <= PTR_WB0;
         wren_q   <= 1'b0;
         addr_q   <= 5'd0;
         data_q   <= 32'd0;
         cnt_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         wren_q   <= wren_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.o_rd_wren      = wren_q;
   assign bus.o_rd_addr      = addr_q;
   assign bus.o_rd_data      = data_q;
   assign bus.o_conflict_cnt = cnt_q;

   // Forward the staged write for the cycle before the register file holds it.
   assign bus.o_rs1_fwd_valid = wren_q & (bus.i_rs1_addr == addr_q) & (bus.i_rs1_addr != 5'd0);
   assign bus.o_rs2_fwd_valid = wren_q & (bus.i_rs2_addr == addr_q) & (bus.i_rs2_addr != 5'd0);
   assign bus.o_rs1_fwd_data  = data_q;
   assign bus.o_rs2_fwd_data  = data_q;

endmodule
